// File: rtl/reqrsp_rr_mux_if.sv
// rtl/reqrsp_rr_mux_if.sv - reqrsp request/response bundle, N packed ports wide
// slave: seen by the block that accepts requests; master: by the block that issues them.
interface reqrsp_rr_mux_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [N-1:0]        q_valid;
  logic [N-1:0]        q_ready;
  logic [N*AW-1:0]     q_addr;
  logic [N-1:0]        q_write;
  logic [N*4-1:0]      q_amo;
  logic [N*DW-1:0]     q_data;
  logic [N*DW/8-1:0]   q_strb;
  logic [N*3-1:0]      q_size;
  logic [N-1:0]        p_valid;
  logic [N-1:0]        p_ready;
  logic [N*DW-1:0]     p_data;
  logic [N-1:0]        p_error;

  modport slave (
    input  q_valid, q_addr, q_write, q_amo, q_data, q_strb, q_size, p_ready,
    output q_ready, p_valid, p_data, p_error
  );

  modport master (
    output q_valid, q_addr, q_write, q_amo, q_data, q_strb, q_size, p_ready,
    input  q_ready, p_valid, p_data, p_error
  );
endinterface

// File: rtl/reqrsp_rr_mux.sv
// rtl/reqrsp_rr_mux.sv - round-robin reqrsp mux with in-order response routing
// Grants are pushed into an ID FIFO; the head selects which port receives the next response.
module reqrsp_rr_mux #(
  parameter int unsigned NrPorts   = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned RespDepth = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  reqrsp_rr_mux_if.slave  slv,
  reqrsp_rr_mux_if.master mst
);
  localparam int unsigned IW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned PW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CW = $clog2(RespDepth + 1);
  localparam int unsigned SW = DW / 8;

  logic [IW-1:0]      rr_q, rr_d;
  logic               lock_q, lock_d;
  logic [IW-1:0]      lock_idx_q, lock_idx_d;
  logic [IW-1:0]      id_mem_q [RespDepth];
  logic [PW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic               full, empty, q_open, q_fire, p_fire, gnt_found;
  logic [IW-1:0]      gnt_idx, head;
  logic [NrPorts-1:0] gnt_oh;
  int unsigned        scan;

  assign full   = (count_q == CW'(RespDepth));
  assign empty  = (count_q == '0);
  // Full blocks requests outright, so a same-cycle pop never reaches the q side.
  assign q_open = !rst_n && !full;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    scan      = 0;
    if (lock_q) begin
      gnt_found = 1'b1;
      gnt_idx   = lock_idx_q;
    end else if (!full) begin
      for (int unsigned i = 0; i < NrPorts; i++) begin
        scan = (32'(rr_q) + i) % NrPorts;
        if (!gnt_found && slv.q_valid[IW'(scan)]) begin
          gnt_found = 1'b1;
          gnt_idx   = IW'(scan);
        end
      end
    end
  end

  assign gnt_oh      = gnt_found ? (NrPorts'(1) << gnt_idx) : '0;
  assign mst.q_valid = gnt_found & slv.q_valid[gnt_idx] & q_open;
  assign mst.q_addr  = slv.q_addr[gnt_idx*AW +: AW];
  assign mst.q_write = slv.q_write[gnt_idx];
  assign mst.q_amo   = slv.q_amo[gnt_idx*4 +: 4];
  assign mst.q_data  = slv.q_data[gnt_idx*DW +: DW];
  assign mst.q_strb  = slv.q_strb[gnt_idx*SW +: SW];
  assign mst.q_size  = slv.q_size[gnt_idx*3 +: 3];
  assign slv.q_ready = (mst.q_ready[0] && q_open) ? gnt_oh : '0;
  assign q_fire      = mst.q_valid[0] & mst.q_ready[0];

  assign head        = id_mem_q[rptr_q];
  assign slv.p_valid = empty ? '0 : (NrPorts'(mst.p_valid) << head);
  assign mst.p_ready = !empty & slv.p_ready[head];
  assign slv.p_data  = {NrPorts{mst.p_data}};
  assign slv.p_error = {NrPorts{mst.p_error}};
  assign p_fire      = mst.p_valid[0] & mst.p_ready[0];

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (q_fire) begin
      lock_d = 1'b0;
      rr_d   = (gnt_idx == IW'(NrPorts - 1)) ? '0 : gnt_idx + 1'b1;
      wptr_d = (wptr_q == PW'(RespDepth - 1)) ? '0 : wptr_q + 1'b1;
    end else if (mst.q_valid[0]) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_idx;
    end
    if (p_fire) begin
      rptr_d = (rptr_q == PW'(RespDepth - 1)) ? '0 : rptr_q + 1'b1;
    end
    case ({q_fire, p_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (q_fire) id_mem_q[wptr_q] <= gnt_idx;
  end

  logic [AW+DW+SW+7:0] payload;
  assign payload = {mst.q_addr, mst.q_write, mst.q_amo, mst.q_data, mst.q_strb, mst.q_size};

  assert property (@(posedge clk) disable iff (rst_n)
    (mst.q_valid[0] && !mst.q_ready[0]) |=> (mst.q_valid[0] && $stable(payload)));
  assert property (@(posedge clk) disable iff (rst_n) $onehot0(gnt_oh));
  assert property (@(posedge clk) disable iff (rst_n) count_q <= CW'(RespDepth));
  assert property (@(posedge clk) disable iff (rst_n) !(empty && mst.p_valid[0]));
endmodule

// File: doc/reqrsp_rr_mux.md
Name: reqrsp_rr_mux

Overview:
- Shares one downstream reqrsp port, e.g. the slave side of the reqrsp-to-AXI converter, between NrPorts upstream reqrsp masters.
- Requests are arbitrated round-robin and forwarded combinationally.
- The granted port index is recorded in an in-order ID FIFO.
- Each downstream response is routed back to the port at the FIFO head. The downstream is required to respond in request order.

Parameters:
NrPorts, 4, number of upstream requesters (>=2)
AW, 32, address width
DW, 32, data width
RespDepth, 8, max outstanding requests (ID FIFO depth, >=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
slv_q_valid_i  in  NrPorts  per-port request valid
slv_q_ready_o  out  NrPorts  per-port request ready
slv_q_addr_i  in  NrPorts*AW  request address
slv_q_write_i  in  NrPorts  write flag
slv_q_amo_i  in  NrPorts*4  AMO opcode (reqrsp_pkg::amo_op_e)
slv_q_data_i  in  NrPorts*DW  write data
slv_q_strb_i  in  NrPorts*DW/8  byte strobe
slv_q_size_i  in  NrPorts*3  access size
slv_p_valid_o  out  NrPorts  response valid
slv_p_ready_i  in  NrPorts  response ready
slv_p_data_o  out  NrPorts*DW  response data (broadcast)
slv_p_error_o  out  NrPorts  response error (broadcast)
mst_q_valid_o/ready_i/addr_o/write_o/amo_o/data_o/strb_o/size_o  out/in/out...  as above, single port
mst_p_valid_i  in  1 ; mst_p_ready_o  out  1 ; mst_p_data_i  in  DW ; mst_p_error_i  in  1

Behaviour:
- Reset (rst_n=1): RR pointer=0, lock flag=0, FIFO empty, count=0. Outputs: mst_q_valid_o=0, all slv_q_ready_o=0, all slv_p_valid_o=0, mst_p_ready_o=0.
- Arbitration (combinational):
  - When unlocked and FIFO not full, grant the first valid port at or after the RR pointer, wrapping NrPorts-1 -> 0.
  - mst_q_* mirrors the granted port's fields. mst_q_valid_o = granted port's valid & !full.
  - slv_q_ready_o[g] = mst_q_ready_i & !full. All other ready bits are 0.
- Stability lock: if mst_q_valid_o=1 and mst_q_ready_i=0, set lock and store the grant index. While locked, the grant is held regardless of other valids, so downstream sees stable payload. Lock clears on the q handshake.
- On q handshake (mst_q_valid_o & mst_q_ready_i):
  - Push the grant index (clog2(NrPorts) bits) into the ID FIFO.
  - RR pointer <= grant+1 mod NrPorts.
  - Latency 0 cycles req->mst.
- FIFO full (count==RespDepth): mst_q_valid_o=0 and all slv_q_ready_o=0, even if a pop occurs in the same cycle. This avoids a p->q combinational path. The lock does not engage while full.
- Response routing:
  - FIFO empty: mst_p_ready_o=0, slv_p_valid_o=0. A response arriving with no outstanding request is a protocol error; an assertion fires and the response is not consumed.
  - FIFO non-empty with head h: slv_p_valid_o[h] = mst_p_valid_i, mst_p_ready_o = slv_p_ready_i[h]. Data and error are broadcast to all ports.
  - On p handshake, pop the head. Latency 0 cycles rsp->slv.
- Simultaneous push and pop (not full): count is unchanged, and head and tail pointers both advance.
- Pointers are wrap-around modulo RespDepth. Count width is clog2(RespDepth+1).
- A port may have several requests outstanding; its responses return in order.
- Assertions:
  - No mst_q payload change while valid and !ready.
  - Grant is onehot0.
  - Count <= RespDepth.
- Mid-operation reset clears the FIFO and lock immediately (async). Outstanding responses are discarded; the environment resets downstream together with this block.

Test Plan:
- Single port 2 active, read addr 0x1000, downstream ready=1 -> mst_q same cycle with addr 0x1000. FIFO holds 2. Response data 0xDEADBEEF appears on slv_p_valid_o[2] only.
- All 4 ports valid continuously, ready=1 -> grant order 0,1,2,3,0,... Each port gets exactly 25% of 400 handshakes.
- Port 1 granted, downstream ready=0 for 5 cycles while port 0 also raises valid -> payload of port 1 held for 5 cycles. Port 0 is granted next.
- RespDepth=8, no responses, 10 requests offered -> exactly 8 accepted, then mst_q_valid_o=0. One response pops the FIFO, and the 9th request is accepted the following cycle.
- Ports 0,3,0 interleaved writes with responses of error=1 on the 2nd -> responses routed 0,3,0. slv_p_error_o=1 is seen by port 3 only, via its valid.
- Assert rst_n mid-burst with 5 outstanding -> all valids and readies 0 within the cycle, count=0. Traffic resumes with the RR pointer at 0.
